// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared states and frame constants for the ROM loader SPI writer
package rom_loader_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_STB, SHIFT, CS_GAP, ACK} state_e;
  localparam int FRAME_BITS = 48;
  localparam int ADDR_BYTES = 3;
  localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h02;
endpackage

// File: rtl/rom_loader_spi_tx.sv
// rom_loader_spi_tx: shifts one MSB-first SPI mode-0 write frame out on sio0
module rom_loader_spi_tx import rom_loader_pkg::*; #(
  parameter int SCK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  done,
  output logic                  cs_n,
  output logic                  sck,
  output logic                  sio_oe,
  output logic                  sio0
);
  localparam int DW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  logic [DW-1:0]         div_q;
  logic [BW-1:0]         bit_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic                  cs_n_q, sck_q;
  logic                  tick;
  assign tick   = !cs_n_q && div_q == DW'(SCK_DIV - 1);
  assign done   = tick && sck_q && bit_q == BW'(FRAME_BITS - 1);
  assign cs_n   = cs_n_q;
  assign sck    = sck_q;
  assign sio_oe = !cs_n_q;
  assign sio0   = sr_q[FRAME_BITS-1];
  // half-period divider toggles sck; data advances on each falling edge, cs releases after the last one
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n_q <= 1'b1;
      sck_q  <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sr_q   <= '0;
    end else if (start) begin
      cs_n_q <= 1'b0;
      sck_q  <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      sr_q   <= frame;
    end else if (!cs_n_q) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        sck_q <= ~sck_q;
        if (sck_q) begin
          sr_q   <= sr_q << 1;
          bit_q  <= done ? bit_q : bit_q + 1'b1;
          cs_n_q <= done;
        end
      end
    end
  end
endmodule

// File: rtl/rom_loader_spi_writer.sv
// rom_loader_spi_writer: takes host words over a strobe/ack handshake and writes them to ROM SRAM over SPI
module rom_loader_spi_writer import rom_loader_pkg::*; #(
  parameter int         ADDR_WIDTH = 16,
  parameter int         SCK_DIV    = 1,
  parameter logic [7:0] CMD_WRITE  = CMD_WRITE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_load,
  input  logic                  ld_sck,
  input  logic [15:0]           ld_data,
  output logic                  ld_ack,
  output logic                  active,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  spi_cs_n,
  output logic                  spi_sck,
  output logic                  spi_sio_oe,
  output logic                  spi_sio0_o,
  output logic                  spi_sio2_o,
  output logic                  spi_sio3_o
);
  localparam int GW  = $clog2(2 * SCK_DIV);
  localparam int ABW = ADDR_BYTES * 8;
  state_e                state_q;
  logic [1:0]            load_s, sck_s;
  logic                  load_p, sck_p;
  logic                  ack_q, active_q, busy_q;
  logic [ADDR_WIDTH-1:0] word_addr_q;
  logic [GW-1:0]         gap_q;
  logic                  load_rise, sck_rise, start, tx_done;
  logic [ABW-1:0]        byte_addr;
  assign load_rise  = load_s[1] && !load_p;
  assign sck_rise   = sck_s[1] && !sck_p;
  assign start      = state_q == WAIT_STB && load_s[1] && sck_rise;
  assign byte_addr  = ABW'({word_addr_q, 1'b0});
  assign ld_ack     = ack_q;
  assign active     = active_q;
  assign busy       = busy_q;
  assign word_addr  = word_addr_q;
  assign spi_sio2_o = 1'b1;
  assign spi_sio3_o = 1'b1;
  // two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      load_s <= '0;
      sck_s  <= '0;
      load_p <= 1'b0;
      sck_p  <= 1'b0;
    end else begin
      load_s <= {load_s[0], ld_load};
      sck_s  <= {sck_s[0], ld_sck};
      load_p <= load_s[1];
      sck_p  <= sck_s[1];
    end
  end
  // handshake FSM: a started frame always runs to completion and is acked before load is re-examined
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      active_q    <= 1'b0;
      busy_q      <= 1'b0;
      word_addr_q <= '0;
      gap_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (load_rise) begin
          state_q     <= WAIT_STB;
          active_q    <= 1'b1;
          word_addr_q <= '0;
        end
        WAIT_STB: if (!load_s[1]) begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end else if (sck_rise) begin
          state_q <= SHIFT;
          busy_q  <= 1'b1;
        end
        SHIFT: if (tx_done) begin
          state_q <= CS_GAP;
          gap_q   <= '0;
        end
        CS_GAP: if (gap_q == GW'(2 * SCK_DIV - 1)) begin
          state_q     <= ACK;
          word_addr_q <= word_addr_q + 1'b1;
          busy_q      <= 1'b0;
          ack_q       <= 1'b1;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
        ACK: if (!sck_s[1]) begin
          ack_q    <= 1'b0;
          active_q <= load_s[1];
          state_q  <= load_s[1] ? WAIT_STB : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  rom_loader_spi_tx #(.SCK_DIV(SCK_DIV)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .frame  ({CMD_WRITE, byte_addr, ld_data}),
    .done   (tx_done),
    .cs_n   (spi_cs_n),
    .sck    (spi_sck),
    .sio_oe (spi_sio_oe),
    .sio0   (spi_sio0_o)
  );
endmodule

// File: tb/tb_rom_loader_spi_writer.sv
// tb_rom_loader_spi_writer: scoreboard bench decoding SPI frames from a 16-bit and a 2-bit address instance
module tb_rom_loader_spi_writer;
  logic        clk, reset;
  logic        ld_load[2], ld_sck[2];
  logic [15:0] ld_data[2];
  logic        ack[2], active[2], busy[2], cs_n[2], sck[2], oe[2], mosi[2], sio2[2], sio3[2];
  logic [15:0] wa0;
  logic [1:0]  wa1;
  int          checks = 0, errors = 0;
  logic [47:0] exp_q[2][$];
  logic        inf[2], psck[2], bad[2];
  int          cnt[2], cs_falls[2];
  logic [47:0] sh[2];
  logic [47:0] e;
  int          n, f;

  rom_loader_spi_writer #(.ADDR_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .ld_load(ld_load[0]), .ld_sck(ld_sck[0]), .ld_data(ld_data[0]),
    .ld_ack(ack[0]), .active(active[0]), .busy(busy[0]), .word_addr(wa0),
    .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_sio_oe(oe[0]), .spi_sio0_o(mosi[0]),
    .spi_sio2_o(sio2[0]), .spi_sio3_o(sio3[0])
  );
  rom_loader_spi_writer #(.ADDR_WIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .ld_load(ld_load[1]), .ld_sck(ld_sck[1]), .ld_data(ld_data[1]),
    .ld_ack(ack[1]), .active(active[1]), .busy(busy[1]), .word_addr(wa1),
    .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_sio_oe(oe[1]), .spi_sio0_o(mosi[1]),
    .spi_sio2_o(sio2[1]), .spi_sio3_o(sio3[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input int d, input logic [15:0] data, input logic [23:0] addr);
    int k;
    exp_q[d].push_back({8'h02, addr, data});
    @(posedge clk); #1;
    ld_data[d] = data;
    ld_sck[d]  = 1'b1;
    k = 0;
    while (!ack[d] && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ack_latency", 64'(k), 64'd101);
  endtask

  task automatic release_word(input int d);
    int k;
    k = 0;
    ld_sck[d] = 1'b0;
    while (ack[d] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ack_release", 64'(ack[d]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // monitor: rebuilds each frame from MOSI on sck rising edges and scores it when cs_n returns high
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        inf[d]  = 1'b0;
        psck[d] = 1'b0;
      end else begin
        if (!cs_n[d] && !inf[d]) begin
          inf[d] = 1'b1;
          cnt[d] = 0;
          sh[d]  = '0;
          bad[d] = 1'b0;
          cs_falls[d]++;
        end
        if (inf[d] && oe[d] == cs_n[d]) bad[d] = 1'b1;
        if (inf[d] && !cs_n[d] && sck[d] && !psck[d]) begin
          sh[d] = {sh[d][46:0], mosi[d]};
          cnt[d]++;
        end
        if (inf[d] && cs_n[d]) begin
          inf[d] = 1'b0;
          chk("frame_queue", 64'(exp_q[d].size()), 64'd1);
          if (exp_q[d].size() != 0) begin
            e = exp_q[d].pop_front();
            chk("frame", 64'(sh[d]), 64'(e));
            chk("sck_edges", 64'(cnt[d]), 64'd48);
            chk("oe_sck_at_end", 64'({bad[d], sck[d]}), 64'd0);
          end
        end
        psck[d] = sck[d];
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      ld_load[d] = 1'b0; ld_sck[d] = 1'b0; ld_data[d] = '0;
      inf[d] = 1'b0; psck[d] = 1'b0; bad[d] = 1'b0; cnt[d] = 0; cs_falls[d] = 0; sh[d] = '0;
    end
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_outputs", 64'({ack[0], active[0], busy[0], cs_n[0], sck[0], oe[0], mosi[0], sio2[0], sio3[0]}),
          64'(9'b000100011));
    end
    chk("idle_word_addr", 64'(wa0), 64'd0);
    ld_sck[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("idle_sck_ignored", 64'({cs_falls[0][3:0], busy[0]}), 64'd0);
    ld_sck[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 ld_load[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("active_on_load", 64'({active[0], wa0}), 64'h10000);
    write_word(0, 16'hBEEF, 24'h000000);
    chk("word_addr_1", 64'(wa0), 64'd1);
    release_word(0);
    write_word(0, 16'h1234, 24'h000002);
    release_word(0);
    write_word(0, 16'h5A5A, 24'h000004);
    release_word(0);
    chk("word_addr_3", 64'(wa0), 64'd3);
    exp_q[0].push_back({8'h02, 24'h000006, 16'hC0DE});
    @(posedge clk); #1;
    ld_data[0] = 16'hC0DE;
    ld_sck[0]  = 1'b1;
    repeat (43) @(posedge clk);
    #1 ld_load[0] = 1'b0;
    n = 43;
    while (!ack[0] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_latency_load_drop", 64'(n), 64'd101);
    f = cs_falls[0];
    repeat (200) @(posedge clk);
    #1 chk("no_rewrite_sck_high", 64'(cs_falls[0]), 64'(f));
    chk("ack_held_sck_high", 64'({ack[0], active[0]}), 64'd3);
    ld_sck[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("idle_after_drop", 64'({ack[0], active[0], wa0}), 64'd4);
    ld_load[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1 ld_data[0] = 16'hDEAD;
    ld_sck[0] = 1'b1;
    repeat (63) @(posedge clk);
    #1 chk("busy_mid_frame", 64'({busy[0], cs_n[0]}), 64'd2);
    reset = 1'b1;
    ld_sck[0] = 1'b0;
    ld_load[0] = 1'b0;
    @(posedge clk); #1;
    chk("reset_abort", 64'({cs_n[0], oe[0], active[0], busy[0], wa0}), 64'h80000);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 ld_load[0] = 1'b1;
    repeat (6) @(posedge clk);
    write_word(0, 16'h0F0F, 24'h000000);
    release_word(0);
    chk("word_addr_after_reset", 64'(wa0), 64'd1);
    ld_load[1] = 1'b1;
    repeat (6) @(posedge clk);
    write_word(1, 16'h1111, 24'h000000); release_word(1);
    write_word(1, 16'h2222, 24'h000002); release_word(1);
    write_word(1, 16'h3333, 24'h000004); release_word(1);
    write_word(1, 16'h4444, 24'h000006); release_word(1);
    chk("wrap_word_addr_0", 64'(wa1), 64'd0);
    write_word(1, 16'h5555, 24'h000000); release_word(1);
    chk("wrap_word_addr_1", 64'(wa1), 64'd1);
    repeat (10) @(posedge clk);
    #1 chk("queues_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
